// File: rtl/dc_mcfetch.sv
// rtl/dc_mcfetch.sv - CRT display fetch engine: turns line/segment requests into single read bursts
module dc_mcfetch #(
  parameter int ADDR_W = 21,
  parameter int LEN_W  = 5
) (
  input  logic              mclock,
  input  logic              hreset,
  input  logic              mcdc_req,
  input  logic [9:0]        mcdcx,
  input  logic [11:0]       mcdcyf,
  input  logic [LEN_W-1:0]  mcdcpg,
  input  logic [ADDR_W-1:0] displ_start_vs,
  input  logic [11:0]       db_pitch,
  input  logic              dc_flush,
  output logic              mcdc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_gnt,
  input  logic              mem_rdvalid,
  input  logic [127:0]      mem_rdata,
  output logic              mcpush,
  output logic [127:0]      datdc_in,
  output logic              fetch_err
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_DATA, S_DONE} state_t;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

  state_t              state_q, state_d;
  logic [9:0]          x_q;
  logic [11:0]         y_q;
  logic [LEN_W-1:0]    pg_q;
  logic [ADDR_W-1:0]   start_q;
  logic [11:0]         pitch_q;
  logic [23:0]         line_off_q;
  logic [LEN_W:0]      cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                push_q, push_d;
  logic [127:0]        data_q;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                latch_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mcdc_req && !dc_flush) begin
          latch_en = 1'b1;
          flush_d  = 1'b0;
          state_d  = S_CALC;
        end
      end
      S_CALC: state_d = S_REQ;
      S_REQ: begin
        // A grant in the same cycle as a flush still commits the burst.
        if (mem_gnt) begin
          cnt_d   = {1'b0, pg_q} + CNT_ONE;
          flush_d = dc_flush;
          state_d = S_DATA;
        end else if (dc_flush) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (dc_flush) flush_d = 1'b1;
        if (mem_rdvalid) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_d  = (state_q == S_DATA) && mem_rdvalid && !(flush_q || dc_flush);
    ready_d = (state_q == S_DONE) && !flush_q;
    err_d   = err_q || (mem_rdvalid && (state_q != S_DATA));
  end

  always_ff @(posedge mclock) begin
    if (hreset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pg_q       <= '0;
      start_q    <= '0;
      pitch_q    <= '0;
      line_off_q <= '0;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      push_q     <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      push_q  <= push_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (latch_en) begin
        x_q     <= mcdcx;
        y_q     <= mcdcyf;
        pg_q    <= mcdcpg;
        start_q <= displ_start_vs;
        pitch_q <= db_pitch;
      end
      if (state_q == S_CALC) line_off_q <= {12'b0, y_q} * {12'b0, pitch_q};
      if (push_d) data_q <= mem_rdata;
    end
  end

  // Address wraps silently at 2^ADDR_W.
  assign mem_addr   = start_q + line_off_q[ADDR_W-1:0] + {{(ADDR_W-10){1'b0}}, x_q};
  assign mem_len    = pg_q;
  assign mem_req    = (state_q == S_REQ);
  assign mcpush     = push_q;
  assign datdc_in   = data_q;
  assign mcdc_ready = ready_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_dc_mcfetch.sv
// tb/tb_dc_mcfetch.sv - self-checking bench for dc_mcfetch
module tb_dc_mcfetch;
  logic         mclock = 1'b0;
  logic         hreset;
  logic         mcdc_req;
  logic [9:0]   mcdcx;
  logic [11:0]  mcdcyf;
  logic [4:0]   mcdcpg;
  logic [20:0]  displ_start_vs;
  logic [11:0]  db_pitch;
  logic         dc_flush;
  logic         mcdc_ready;
  logic         mem_req;
  logic [20:0]  mem_addr;
  logic [4:0]   mem_len;
  logic         mem_gnt;
  logic         mem_rdvalid;
  logic [127:0] mem_rdata;
  logic         mcpush;
  logic [127:0] datdc_in;
  logic         fetch_err;

  int checks = 0;
  int passed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_d;

  dc_mcfetch #(.ADDR_W(21), .LEN_W(5)) dut (
    .mclock(mclock), .hreset(hreset), .mcdc_req(mcdc_req), .mcdcx(mcdcx),
    .mcdcyf(mcdcyf), .mcdcpg(mcdcpg), .displ_start_vs(displ_start_vs),
    .db_pitch(db_pitch), .dc_flush(dc_flush), .mcdc_ready(mcdc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_gnt(mem_gnt),
    .mem_rdvalid(mem_rdvalid), .mem_rdata(mem_rdata), .mcpush(mcpush),
    .datdc_in(datdc_in), .fetch_err(fetch_err)
  );

  always #5 mclock = ~mclock;

  task automatic tick();
    @(posedge mclock);
    #1;
  endtask

  // Presents a request in IDLE and returns with the DUT in REQ.
  task automatic issue(input logic [20:0] start, input logic [11:0] pitch,
                       input logic [11:0] y, input logic [9:0] x, input logic [4:0] pg);
    displ_start_vs = start; db_pitch = pitch; mcdcyf = y; mcdcx = x; mcdcpg = pg;
    mcdc_req = 1'b1;
    tick();
    mcdc_req = 1'b0;
    tick();
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    tick();
    checks++; if ({mem_req, mcpush, mcdc_ready, fetch_err} !== 4'b0) $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mcpush, mcdc_ready, fetch_err}); else passed++;
    checks++; if (mem_addr !== 21'h0 || mem_len !== 5'h0 || datdc_in !== 128'h0) $display("FAIL reset_data: got addr %h len %h data %h expected 0", mem_addr, mem_len, datdc_in); else passed++;
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int early_ready = 0;
    issue(21'h000100, 12'h0A0, 12'd2, 10'd4, 5'd7);
    checks++; if (mem_req !== 1'b1) $display("FAIL basic_req: got %b expected 1", mem_req); else passed++;
    checks++; if (mem_addr !== 21'h000244) $display("FAIL basic_addr: got %h expected 000244", mem_addr); else passed++;
    checks++; if (mem_len !== 5'd7) $display("FAIL basic_len: got %0d expected 7", mem_len); else passed++;
    repeat (3) tick();
    checks++; if (mem_req !== 1'b1) $display("FAIL basic_req_held: got %b expected 1", mem_req); else passed++;
    grant();
    checks++; if (mem_req !== 1'b0) $display("FAIL basic_req_drop: got %b expected 0", mem_req); else passed++;
    for (int i = 0; i < 8; i++) begin
      mem_rdvalid = 1'b1;
      mem_rdata = 128'(i);
      exp_q.push_back(128'(i));
      tick();
      if (mcdc_ready) early_ready++;
      checks++;
      if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL basic_push%0d: got %b expected 1", i, mcpush);
      else begin
        exp_d = exp_q.pop_front();
        if (datdc_in !== exp_d) $display("FAIL basic_data%0d: got %h expected %h", i, datdc_in, exp_d); else passed++;
      end
    end
    mem_rdvalid = 1'b0;
    checks++; if (early_ready != 0) $display("FAIL basic_early_ready: got %0d expected 0", early_ready); else passed++;
    tick();
    checks++; if (mcdc_ready !== 1'b1 || mcpush !== 1'b0) $display("FAIL basic_ready: got ready %b push %b expected 1 0", mcdc_ready, mcpush); else passed++;
    tick();
    checks++; if (mcdc_ready !== 1'b0) $display("FAIL basic_ready_pulse: got %b expected 0", mcdc_ready); else passed++;
  endtask

  task automatic test_wrap();
    logic [127:0] d;
    issue(21'h1FFFF0, 12'h010, 12'd1, 10'd0, 5'd0);
    checks++; if (mem_addr !== 21'h000000 || mem_len !== 5'd0) $display("FAIL wrap_addr: got %h/%0d expected 000000/0", mem_addr, mem_len); else passed++;
    grant();
    d = {$urandom, $urandom, $urandom, $urandom};
    mem_rdvalid = 1'b1; mem_rdata = d; exp_q.push_back(d);
    tick();
    mem_rdvalid = 1'b0;
    checks++;
    if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL wrap_push: got %b expected 1", mcpush);
    else begin
      exp_d = exp_q.pop_front();
      if (datdc_in !== exp_d) $display("FAIL wrap_data: got %h expected %h", datdc_in, exp_d); else passed++;
    end
    tick();
    checks++; if (mcdc_ready !== 1'b1) $display("FAIL wrap_ready: got %b expected 1", mcdc_ready); else passed++;
    tick();
  endtask

  task automatic test_flush_req();
    int ready_seen = 0;
    issue(21'h000400, 12'h020, 12'd1, 10'd2, 5'd3);
    checks++; if (mem_req !== 1'b1) $display("FAIL flreq_req: got %b expected 1", mem_req); else passed++;
    dc_flush = 1'b1; mcdc_req = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0) $display("FAIL flreq_drop: got %b expected 0", mem_req); else passed++;
    if (mcdc_ready) ready_seen++;
    mcdcpg = 5'd0;
    tick();
    if (mcdc_ready) ready_seen++;
    dc_flush = 1'b0;
    tick();
    if (mcdc_ready) ready_seen++;
    checks++; if (mem_req !== 1'b0) $display("FAIL flreq_calc: got %b expected 0", mem_req); else passed++;
    mcdc_req = 1'b0;
    tick();
    if (mcdc_ready) ready_seen++;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000422) $display("FAIL flreq_reissue: got req %b addr %h expected 1 000422", mem_req, mem_addr); else passed++;
    checks++; if (ready_seen != 0) $display("FAIL flreq_no_ready: got %0d expected 0", ready_seen); else passed++;
    grant();
    mem_rdvalid = 1'b1; mem_rdata = 128'hABCD; exp_q.push_back(128'hABCD);
    tick();
    mem_rdvalid = 1'b0;
    checks++;
    if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL flreq_push: got %b expected 1", mcpush);
    else begin
      exp_d = exp_q.pop_front();
      if (datdc_in !== exp_d) $display("FAIL flreq_data: got %h expected %h", datdc_in, exp_d); else passed++;
    end
    tick();
    checks++; if (mcdc_ready !== 1'b1) $display("FAIL flreq_ready: got %b expected 1", mcdc_ready); else passed++;
    tick();
  endtask

  task automatic test_flush_data();
    int pushes_after = 0;
    int ready_seen = 0;
    issue(21'h001000, 12'h020, 12'd3, 10'd1, 5'd3);
    checks++; if (mem_addr !== 21'h001061) $display("FAIL fldat_addr: got %h expected 001061", mem_addr); else passed++;
    grant();
    for (int i = 0; i < 2; i++) begin
      mem_rdvalid = 1'b1; mem_rdata = 128'(100 + i); exp_q.push_back(128'(100 + i));
      tick();
      checks++;
      if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL fldat_push%0d: got %b expected 1", i, mcpush);
      else begin
        exp_d = exp_q.pop_front();
        if (datdc_in !== exp_d) $display("FAIL fldat_data%0d: got %h expected %h", i, datdc_in, exp_d); else passed++;
      end
    end
    mem_rdvalid = 1'b0; dc_flush = 1'b1;
    tick();
    if (mcpush) pushes_after++;
    dc_flush = 1'b0;
    for (int i = 2; i < 4; i++) begin
      mem_rdvalid = 1'b1; mem_rdata = 128'(100 + i);
      tick();
      if (mcpush) pushes_after++;
      if (mcdc_ready) ready_seen++;
    end
    mem_rdvalid = 1'b0;
    tick();
    if (mcdc_ready) ready_seen++;
    tick();
    if (mcdc_ready) ready_seen++;
    checks++; if (pushes_after != 0) $display("FAIL fldat_no_push: got %0d expected 0", pushes_after); else passed++;
    checks++; if (ready_seen != 0) $display("FAIL fldat_no_ready: got %0d expected 0", ready_seen); else passed++;
    checks++; if (fetch_err !== 1'b0) $display("FAIL fldat_err: got %b expected 0", fetch_err); else passed++;
    issue(21'h000010, 12'h001, 12'd0, 10'd0, 5'd0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000010) $display("FAIL fldat_next: got req %b addr %h expected 1 000010", mem_req, mem_addr); else passed++;
    grant();
    mem_rdvalid = 1'b1; mem_rdata = 128'h77; exp_q.push_back(128'h77);
    tick();
    mem_rdvalid = 1'b0;
    if (mcpush && exp_q.size() != 0) exp_d = exp_q.pop_front();
    tick();
    checks++; if (mcdc_ready !== 1'b1) $display("FAIL fldat_next_ready: got %b expected 1", mcdc_ready); else passed++;
    tick();
  endtask

  task automatic test_stray();
    mem_rdvalid = 1'b1; mem_rdata = 128'hDEAD;
    tick();
    mem_rdvalid = 1'b0;
    checks++; if (mcpush !== 1'b0 || fetch_err !== 1'b1) $display("FAIL stray: got push %b err %b expected 0 1", mcpush, fetch_err); else passed++;
    repeat (4) tick();
    checks++; if (fetch_err !== 1'b1) $display("FAIL stray_sticky: got %b expected 1", fetch_err); else passed++;
  endtask

  task automatic test_reset_mid_data();
    issue(21'h000200, 12'h040, 12'd1, 10'd0, 5'd7);
    grant();
    for (int i = 0; i < 3; i++) begin
      mem_rdvalid = 1'b1; mem_rdata = 128'(200 + i); exp_q.push_back(128'(200 + i));
      tick();
      checks++;
      if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL rstmid_push%0d: got %b expected 1", i, mcpush);
      else begin
        exp_d = exp_q.pop_front();
        if (datdc_in !== exp_d) $display("FAIL rstmid_data%0d: got %h expected %h", i, datdc_in, exp_d); else passed++;
      end
    end
    mem_rdvalid = 1'b0; hreset = 1'b1;
    tick();
    hreset = 1'b0;
    checks++; if ({mem_req, mcpush, mcdc_ready, fetch_err} !== 4'b0) $display("FAIL rstmid_outs: got %b expected 0000", {mem_req, mcpush, mcdc_ready, fetch_err}); else passed++;
    checks++; if (mem_addr !== 21'h0) $display("FAIL rstmid_addr: got %h expected 000000", mem_addr); else passed++;
    repeat (2) tick();
    checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_idle: got %b expected 0", mem_req); else passed++;
    issue(21'h000300, 12'h010, 12'd2, 10'd5, 5'd1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 21'h000325 || mem_len !== 5'd1) $display("FAIL rstmid_next: got req %b addr %h len %0d expected 1 000325 1", mem_req, mem_addr, mem_len); else passed++;
    grant();
    for (int i = 0; i < 2; i++) begin
      mem_rdvalid = 1'b1; mem_rdata = 128'(300 + i); exp_q.push_back(128'(300 + i));
      tick();
      checks++;
      if (mcpush !== 1'b1 || exp_q.size() == 0) $display("FAIL rstmid_npush%0d: got %b expected 1", i, mcpush);
      else begin
        exp_d = exp_q.pop_front();
        if (datdc_in !== exp_d) $display("FAIL rstmid_ndata%0d: got %h expected %h", i, datdc_in, exp_d); else passed++;
      end
    end
    mem_rdvalid = 1'b0;
    tick();
    checks++; if (mcdc_ready !== 1'b1 || fetch_err !== 1'b0) $display("FAIL rstmid_ready: got ready %b err %b expected 1 0", mcdc_ready, fetch_err); else passed++;
    tick();
  endtask

  initial begin
    hreset = 1'b1; mcdc_req = 1'b0; mcdcx = '0; mcdcyf = '0; mcdcpg = '0;
    displ_start_vs = '0; db_pitch = '0; dc_flush = 1'b0; mem_gnt = 1'b0;
    mem_rdvalid = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    test_reset();
    test_basic();
    test_wrap();
    test_flush_req();
    test_flush_data();
    test_stray();
    test_reset_mid_data();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dc_mcfetch.md
Name: dc_mcfetch

Overview:
- Display-fetch engine on the memory clock, directly upstream of the CRT display FIFO.
- Takes the CRT's line/segment fetch requests (mcdc_req, mcdcx, mcdcyf, mcdcpg) and converts each into one linear 128-bit-word memory read burst, using the display start address and pitch.
- Returns the read data to the CRT as mcpush/datdc_in, and signals completion to it on mcdc_ready.
- Only one burst is ever outstanding.

Parameters:
- ADDR_W, 21, memory word-address width (16-byte words, byte address bits [24:4]).
- LEN_W, 5, width of the burst-length code mcdcpg.

Ports:
- mclock  in  1  memory clock; the only clock.
- hreset  in  1  synchronous, active-high reset.
- mcdc_req  in  1  CRT fetch request (level); sampled only in IDLE.
- mcdcx  in  10  x offset within the line, in 16-byte words.
- mcdcyf  in  12  line number.
- mcdcpg  in  LEN_W  burst length code; burst length is mcdcpg+1 words (1..32).
- displ_start_vs  in  ADDR_W  display start word address.
- db_pitch  in  12  line pitch in 16-byte words.
- dc_flush  in  1  abort/flush (vsync); level.
- mcdc_ready  out  1  one-cycle pulse when a burst has completed.
- mem_req  out  1  read request to the memory arbiter.
- mem_addr  out  ADDR_W  burst start word address.
- mem_len  out  LEN_W  burst length code (mcdcpg, as latched).
- mem_gnt  in  1  arbiter accept; request completes in the cycle mem_req&mem_gnt.
- mem_rdvalid  in  1  read beat valid.
- mem_rdata  in  128  read beat data.
- mcpush  out  1  FIFO write strobe to the CRT.
- datdc_in  out  128  FIFO write data.
- fetch_err  out  1  sticky: a read beat arrived while no burst was in DATA.

Behaviour:
- Reset: hreset is checked at the clock edge and overrides everything, mid-burst included. All outputs go to 0, the FSM goes to IDLE, the beat counter clears and fetch_err clears.
- IDLE:
  - If mcdc_req=1 and dc_flush=0: latch mcdcx, mcdcyf, mcdcpg, displ_start_vs and db_pitch, then go to CALC.
  - Otherwise stay in IDLE.
- CALC (1 cycle):
  - line_off = mcdcyf*db_pitch (24-bit product, registered).
  - Next cycle: mem_addr = (start + line_off[ADDR_W-1:0] + mcdcx) mod 2^ADDR_W. Wrap-around is silent.
  - Go to REQ.
- REQ:
  - mem_req=1, with mem_addr and mem_len held stable.
  - On mem_req&mem_gnt: go to DATA with beat count = mcdcpg+1.
  - If dc_flush=1 with no grant: drop mem_req and return to IDLE. No mcdc_ready.
  - If dc_flush and mem_gnt occur in the same cycle, the grant wins: go to DATA in flush mode.
- DATA:
  - Each mem_rdvalid decrements the beat count.
  - mcpush/datdc_in are registered copies of mem_rdvalid/mem_rdata, so latency is 1 cycle.
  - On the last beat, go to DONE.
  - If dc_flush is seen at any point during DATA (sticky flush flag), remaining beats are still consumed but mcpush stays 0.
- DONE (1 cycle):
  - mcdc_ready=1 unless the flush flag is set.
  - Return to IDLE.
  - mcdc_req may still be high; it is re-sampled on the next IDLE cycle, so the minimum request-to-request spacing is IDLE→CALC→REQ→DATA→DONE.
- mem_rdvalid in any state other than DATA: ignored, no push, fetch_err set to 1.
- No back-pressure from the FIFO. The CRT must hold mcdc_req low when the FIFO lacks room for 32 words.

Test Plan:
- Reset mid-DATA (after 3 of 8 beats): assert hreset for 1 cycle → mem_req=0, mcpush=0, mcdc_ready=0 and fetch_err=0 next cycle; FSM in IDLE; the next request fetches normally.
- Basic fetch, with start=0x000100, pitch=0x0A0, y=2, x=4, pg=7, gnt 3 cycles after mem_req:
  - mem_addr=0x000244 and mem_len=7.
  - 8 beats with data 0..7 produce mcpush on 8 cycles, each one cycle after its mem_rdvalid, with matching data.
  - mcdc_ready pulses once, 1 cycle after the final push.
- Wrap, with start=0x1FFFF0, pitch=0x010, y=1, x=0 → mem_addr=0x000000.
- Flush in REQ (dc_flush during REQ, gnt never arrives) → mem_req drops next cycle; no mcdc_ready; an immediately following request is accepted once dc_flush=0.
- Flush in DATA (dc_flush after 2 of 4 beats) → 2 pushes then none; all 4 beats consumed; no mcdc_ready; fetch_err=0.
- Stray beat (mem_rdvalid in IDLE) → no mcpush; fetch_err=1 and stays set until hreset.
